// File: rtl/div_result_fifo.sv
// div_result_fifo
//   Capture stage behind the 4-bit integer divider. Each rising edge of the
//   divider's done level stores {error, remainder, quotient} into a small
//   first-word-fall-through FIFO. The consumer drains that FIFO through a
//   valid/ready handshake. A result that arrives while the FIFO is full is
//   dropped, and the sticky overflow flag records the drop.
//
//   Optional statistics: define DIV_RESULT_STATS_EN to add res_cnt/err_cnt.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   done_in        divider done level; one result per 0->1 transition
//   error_in       divider error flag, sampled with done_in
//   quotient_in    divider quotient
//   remainder_in   divider remainder
//   out_valid      head entry available
//   out_ready      consumer accepts the head entry
//   out_quotient   head entry quotient
//   out_remainder  head entry remainder
//   out_error      head entry error flag
//   count          number of stored entries, 0..DEPTH
//   full           count == DEPTH
//   overflow       sticky: a result was dropped
//   ovf_clr        synchronous clear of overflow
//   res_cnt        (DIV_RESULT_STATS_EN) accepted pushes, saturating at 255
//   err_cnt        (DIV_RESULT_STATS_EN) accepted error pushes, saturating at 255
//
// Handshake: the head entry transfers on every rising clk edge where
// out_valid=1 and out_ready=1. out_valid never depends on out_ready.
// out_ready is ignored while out_valid=0. The head data stays stable
// until it transfers.
module div_result_fifo #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4,
   parameter int AW     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              done_in,
   input  logic              error_in,
   input  logic [DATA_W-1:0] quotient_in,
   input  logic [DATA_W-1:0] remainder_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_quotient,
   output logic [DATA_W-1:0] out_remainder,
   output logic              out_error,
   output logic [AW:0]       count,
   output logic              full,
   output logic              overflow,
   input  logic              ovf_clr
`ifdef DIV_RESULT_STATS_EN
   ,
   output logic [7:0]        res_cnt,
   output logic [7:0]        err_cnt
`endif
);

   localparam int          EW      = 2 * DATA_W + 1;
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          done_d;
   logic          capture;
   logic          pop;
   logic          push;
   logic          drop;

   assign capture = done_in & ~done_d;
   assign pop     = out_valid & out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push    = capture & (~full | pop);
   assign drop    = capture & full & ~pop;

   assign out_valid = (count != '0);
   assign full      = (count == DEPTH_C);
   assign {out_error, out_remainder, out_quotient} = mem[rd_ptr];

   // Storage carries no reset. Stale words are never visible because out_valid gates them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {error_in, remainder_in, quotient_in};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         // Reset done_d to 1 so a done level held across reset is not captured again.
         done_d   <= 1'b1;
      end else begin
         done_d <= done_in;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
         // A drop in the same cycle as ovf_clr takes priority, so the drop is not lost.
         if (drop) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

`ifdef DIV_RESULT_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_cnt <= '0;
         err_cnt <= '0;
      end else if (push) begin
         if (res_cnt != 8'hFF) begin
            res_cnt <= res_cnt + 8'd1;
         end
         if (error_in && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_div_result_fifo.sv
module tb_div_result_fifo;

   localparam int DATA_W = 4;
   localparam int DEPTH  = 4;
   localparam int AW     = 2;

   logic              clk;
   logic              rst;
   logic              done_in;
   logic              error_in;
   logic [DATA_W-1:0] quotient_in;
   logic [DATA_W-1:0] remainder_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_quotient;
   logic [DATA_W-1:0] out_remainder;
   logic              out_error;
   logic [AW:0]       count;
   logic              full;
   logic              overflow;
   logic              ovf_clr;
`ifdef DIV_RESULT_STATS_EN
   logic [7:0]        res_cnt;
   logic [7:0]        err_cnt;
`endif

   div_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .done_in       (done_in),
      .error_in      (error_in),
      .quotient_in   (quotient_in),
      .remainder_in  (remainder_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder),
      .out_error     (out_error),
      .count         (count),
      .full          (full),
      .overflow      (overflow),
      .ovf_clr       (ovf_clr)
`ifdef DIV_RESULT_STATS_EN
      ,
      .res_cnt       (res_cnt),
      .err_cnt       (err_cnt)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [2*DATA_W:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Every accepted transfer must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop", 1, 0);
         end else begin
            check("pop_data", int'({out_error, out_remainder, out_quotient}), int'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit d, input logic [3:0] q, input logic [3:0] r, input bit e);
      done_in      = d;
      quotient_in  = q;
      remainder_in = r;
      error_in     = e;
   endtask

   task automatic expect_push(input logic [3:0] q, input logic [3:0] r, input bit e);
      exp_q.push_back({e, r, q});
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit         done;
      logic [3:0] q;
      bit         e;
      bit         rdy;
      bit         clr;
      bit         acc;
      int         exp_count;
      bit         exp_valid;
      bit         exp_full;
      bit         exp_ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit d, input int q, input bit rdy, input bit clr, input bit acc,
                      input int cnt, input bit v, input bit f, input bit o);
      vec_t t;
      t.done = d; t.q = 4'(q); t.e = 1'b0; t.rdy = rdy; t.clr = clr; t.acc = acc;
      t.exp_count = cnt; t.exp_valid = v; t.exp_full = f; t.exp_ovf = o;
      tbl.push_back(t);
   endtask

   initial begin
      rst = 1'b0; ovf_clr = 1'b0; out_ready = 1'b0;
      set_in(1'b0, 4'd0, 4'd0, 1'b0);

      // fill to full, then one dropped result
      add(1, 0, 0, 0, 1, 1, 1, 0, 0);  add(0, 0, 0, 0, 0, 1, 1, 0, 0);
      add(1, 1, 0, 0, 1, 2, 1, 0, 0);  add(0, 1, 0, 0, 0, 2, 1, 0, 0);
      add(1, 2, 0, 0, 1, 3, 1, 0, 0);  add(0, 2, 0, 0, 0, 3, 1, 0, 0);
      add(1, 3, 0, 0, 1, 4, 1, 1, 0);  add(0, 3, 0, 0, 0, 4, 1, 1, 0);
      add(1, 4, 0, 0, 0, 4, 1, 1, 1);  add(0, 4, 0, 0, 0, 4, 1, 1, 1);
      // drain, then out_ready on an empty FIFO, then clear overflow
      add(0, 0, 1, 0, 0, 3, 1, 0, 1);  add(0, 0, 1, 0, 0, 2, 1, 0, 1);
      add(0, 0, 1, 0, 0, 1, 1, 0, 1);  add(0, 0, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1);  add(0, 0, 0, 1, 0, 0, 0, 0, 0);
      // refill, then push and pop together while full
      add(1, 5, 0, 0, 1, 1, 1, 0, 0);  add(0, 5, 0, 0, 0, 1, 1, 0, 0);
      add(1, 6, 0, 0, 1, 2, 1, 0, 0);  add(0, 6, 0, 0, 0, 2, 1, 0, 0);
      add(1, 7, 0, 0, 1, 3, 1, 0, 0);  add(0, 7, 0, 0, 0, 3, 1, 0, 0);
      add(1, 8, 0, 0, 1, 4, 1, 1, 0);  add(0, 8, 0, 0, 0, 4, 1, 1, 0);
      add(1, 9, 1, 0, 1, 4, 1, 1, 0);  add(0, 9, 0, 0, 0, 4, 1, 1, 0);
      // a drop wins over ovf_clr in the same cycle
      add(1, 10, 0, 1, 0, 4, 1, 1, 1); add(0, 10, 0, 1, 0, 4, 1, 1, 0);
      add(0, 0, 1, 0, 0, 3, 1, 0, 0);  add(0, 0, 1, 0, 0, 2, 1, 0, 0);
      add(0, 0, 1, 0, 0, 1, 1, 0, 0);  add(0, 0, 1, 0, 0, 0, 0, 0, 0);
      // push into an empty FIFO with out_ready already high
      add(1, 11, 1, 0, 1, 1, 1, 0, 0); add(0, 11, 1, 0, 0, 0, 0, 0, 0);

      // reset state
      #3;
      check("rst_count", int'(count), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_full", int'(full), 0);
      check("rst_ovf", int'(overflow), 0);
      #20 rst = 1'b1;
      tick();

      // single result: a long done level produces exactly one entry
      set_in(1'b1, 4'd1, 4'd1, 1'b0);
      expect_push(4'd1, 4'd1, 1'b0);
      tick();
      check("single_count", int'(count), 1);
      check("single_valid", int'(out_valid), 1);
      check("single_quo", int'(out_quotient), 1);
      check("single_rem", int'(out_remainder), 1);
      for (int i = 0; i < 9; i++) begin
         tick();
         check("single_hold_count", int'(count), 1);
      end
      done_in = 1'b0;
      tick();
      check("single_after_fall", int'(count), 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("single_drained", int'(count), 0);

      // error entry
      set_in(1'b1, 4'd0, 4'd0, 1'b1);
      expect_push(4'd0, 4'd0, 1'b1);
      tick();
      check("err_head_flag", int'(out_error), 1);
      check("err_head_valid", int'(out_valid), 1);
      done_in = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("err_popped_valid", int'(out_valid), 0);
      check("err_popped_count", int'(count), 0);

      // table-driven vectors
      for (int i = 0; i < tbl.size(); i++) begin
         set_in(tbl[i].done, tbl[i].q, ~tbl[i].q, tbl[i].e);
         out_ready = tbl[i].rdy;
         ovf_clr   = tbl[i].clr;
         if (tbl[i].acc) expect_push(tbl[i].q, ~tbl[i].q, tbl[i].e);
         tick();
         check($sformatf("vec%0d_count", i), int'(count), tbl[i].exp_count);
         check($sformatf("vec%0d_valid", i), int'(out_valid), int'(tbl[i].exp_valid));
         check($sformatf("vec%0d_full", i), int'(full), int'(tbl[i].exp_full));
         check($sformatf("vec%0d_ovf", i), int'(overflow), int'(tbl[i].exp_ovf));
      end
      out_ready = 1'b0; ovf_clr = 1'b0; done_in = 1'b0;
      tick();

      // reset mid-stream with done held high
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 4'(12 + i), 4'(i), 1'b0);
         expect_push(4'(12 + i), 4'(i), 1'b0);
         tick();
         if (i < 2) begin
            done_in = 1'b0;
            tick();
         end
      end
      check("mid_pre_count", int'(count), 3);
      #3 rst = 1'b0;
      #1;
      check("mid_rst_count", int'(count), 0);
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_ovf", int'(overflow), 0);
      exp_q.delete();
      @(posedge clk);
      #4 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("mid_held_done", int'(count), 0);
      end
      done_in = 1'b0;
      tick();
      set_in(1'b1, 4'd7, 4'd2, 1'b0);
      expect_push(4'd7, 4'd2, 1'b0);
      tick();
      check("mid_new_edge", int'(count), 1);
      done_in = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("mid_drained", int'(count), 0);

`ifdef DIV_RESULT_STATS_EN
      // statistics: 300 accepted pushes, every third an error
      rst = 1'b0;
      #7 rst = 1'b1;
      tick();
      check("stats_rst_res", int'(res_cnt), 0);
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         set_in(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), (i % 3) == 0);
         expect_push(quotient_in, remainder_in, error_in);
         tick();
         done_in = 1'b0;
         tick();
      end
      out_ready = 1'b0;
      tick();
      check("stats_res_cnt", int'(res_cnt), 255);
      check("stats_err_cnt", int'(err_cnt), 100);
      check("stats_empty", int'(count), 0);
`endif

      check("scoreboard_left", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_result_fifo.md
Name: div_result_fifo

Overview:
- Downstream capture stage for the 4-bit integer divider.
- Detects each rising edge of the divider's done level and stores {error, remainder, quotient} into a small first-word-fall-through FIFO.
- Presents stored entries to the consumer through a valid/ready handshake, so the divider can be restarted with go before the consumer has taken the previous result.
- Drops results when full and flags the drop with a sticky overflow bit.

Parameters:
- DATA_W, 4: width of quotient_in/remainder_in and out_quotient/out_remainder.
- DEPTH, 4: number of FIFO entries; must be a power of 2, minimum 2.
- AW, 2: pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- done_in  in  1  divider done level; one result per 0->1 transition.
- error_in  in  1  divider error flag (divide by zero), sampled with done_in.
- quotient_in  in  DATA_W  divider quotient.
- remainder_in  in  DATA_W  divider remainder.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry when out_valid=1.
- out_quotient  out  DATA_W  head entry quotient.
- out_remainder  out  DATA_W  head entry remainder.
- out_error  out  1  head entry error flag.
- count  out  AW+1  number of stored entries, 0..DEPTH.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky flag: a result was dropped.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - rd_ptr=0, wr_ptr=0, count=0.
  - out_valid=0, full=0, overflow=0.
  - done_d=1, so a done level held across reset is not captured again.
  - Stat counters = 0 (when enabled).
- Reset asserted mid-stream discards all entries. Memory contents need not be cleared.
- Edge detect: capture = done_in & ~done_d. done_d <= done_in every cycle. A done level held for many cycles produces exactly one entry.
- Push: on capture, if push_ok = (~full | pop), write {error_in, remainder_in, quotient_in} to mem[wr_ptr] and set wr_ptr <= wr_ptr+1. The pointer wraps modulo DEPTH.
- Pop: pop = out_valid & out_ready. On pop, rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, the pop frees the slot and the push is accepted.
  - When empty (out_valid=0), there is no pop and the push lands normally.
- Drop: capture with full=1 and no pop. The entry is discarded, pointers and count are unchanged, and overflow <= 1.
- overflow stays set until ovf_clr=1 at a clock edge. If ovf_clr and a new drop occur in the same cycle, the drop wins and overflow stays 1.
- Output timing:
  - out_* = mem[rd_ptr]; out_valid = (count!=0).
  - Latency: done_in rising before edge k into an empty FIFO gives out_valid=1 and the correct data in the cycle after edge k.
- out_ready while out_valid=0 is ignored.
- Output data is held stable while out_valid=1 and out_ready=0.
- error entries are stored and popped like any other entry. Quotient and remainder are stored exactly as received.
- count and full are registered or derived from registered state only.

Optional Feature:
- Macro: DIV_RESULT_STATS_EN.
- Defined:
  - Adds outputs res_cnt[7:0] and err_cnt[7:0].
  - res_cnt increments on every accepted push.
  - err_cnt increments on every accepted push with error_in=1.
  - Both saturate at 255 and clear only on reset. Dropped results are not counted.
- Not defined: these ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Single result: after reset, drive quotient_in=1, remainder_in=1, error_in=0; raise done_in and hold it 10 cycles with out_ready=0 -> exactly one entry. count=1 and out_valid=1 from the cycle after the first edge; out_quotient=1, out_remainder=1.
- Fill and overflow: push 4 results (q=0..3) with out_ready=0, then a 5th (q=4) -> full=1, count=4, overflow=1, head q=0. Pop all -> q order 0,1,2,3, q=4 never appears. ovf_clr=1 -> overflow=0.
- Full with simultaneous push and pop: when full, raise done with q=9 in the same cycle as out_ready=1 -> count stays 4, overflow stays 0, q=9 is popped last.
- Error entry: divisor-zero result error_in=1, q=0, r=0 -> out_error=1 at head; pop -> out_valid=0, count=0.
- Reset mid-stream: 3 entries stored with done_in held high; pull rst low asynchronously, mid-cycle -> count=0, out_valid=0, overflow=0 immediately. Release rst with done_in still high -> no new entry until done_in falls and rises again.
- DIV_RESULT_STATS_EN build: 300 pushes (popping concurrently), every third with error_in=1 -> res_cnt=255 (saturated), err_cnt=100.
